// File: rtl/canon_sequencer_if.sv
// Sequencer-side bus: melody ROM address/data, run controls, and the
// slot counter / divider pair consumed by the wavetable sampler.
interface canon_sequencer_if;
    logic        ena;
    logic        loop;
    logic [5:0]  note_in;
    logic [5:0]  step_addr;
    logic [10:0] counter;
    logic [10:0] divider;
    logic        playing;
    logic        step_pulse;
    logic        done;

    modport master (
        input  ena, loop, note_in,
        output step_addr, counter, divider, playing, step_pulse, done
    );

    modport slave (
        output ena, loop, note_in,
        input  step_addr, counter, divider, playing, step_pulse, done
    );
endinterface

// File: rtl/canon_sequencer.sv
// Melody sequencer for the four-voice PWM sampler: steps a note ROM at a fixed
// tempo and hands a frame-aligned phase-step divider to the sampler.
module canon_sequencer #(
    parameter logic [23:0] STEP_CYCLES = 24'd3000000,
    parameter logic [23:0] GAP_CYCLES  = 24'd300000,
    parameter int unsigned SONG_LEN    = 32
) (
    input logic               clk,
    input logic               rst_n,
    canon_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

    state_t      state;
    logic [23:0] beat;
    logic [5:0]  step_addr;
    logic [10:0] counter;
    logic [10:0] divider;
    logic [10:0] base;
    logic [10:0] pend;
    logic        step_pulse;
    logic        last_step;

    assign last_step = (step_addr == 6'(SONG_LEN - 1));

    always_comb begin
        base = 11'd0;
        case (bus.note_in[3:0])
            4'd0:  base = 11'd1824;
            4'd1:  base = 11'd1722;
            4'd2:  base = 11'd1625;
            4'd3:  base = 11'd1534;
            4'd4:  base = 11'd1448;
            4'd5:  base = 11'd1367;
            4'd6:  base = 11'd1290;
            4'd7:  base = 11'd1218;
            4'd8:  base = 11'd1149;
            4'd9:  base = 11'd1085;
            4'd10: base = 11'd1024;
            4'd11: base = 11'd967;
            default: base = 11'd0;
        endcase
    end

    // Rests map to base 0, so only state and ena gate the pending value.
    always_comb begin
        pend = 11'd0;
        if (state == PLAY && bus.ena)
            pend = base >> bus.note_in[5:4];
    end

    // Counter runs regardless of state; the divider only moves on the last
    // slot of a 4-slot frame so every voice in a frame sees one value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter <= 11'd0;
            divider <= 11'd0;
        end else begin
            counter <= counter + 11'd1;
            if (counter[1:0] == 2'b11)
                divider <= pend;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= 24'd0;
            step_addr  <= 6'd0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                IDLE: if (bus.ena) begin
                    state     <= PLAY;
                    step_addr <= 6'd0;
                    beat      <= STEP_CYCLES - 24'd1;
                end
                PLAY, GAP: if (bus.ena) begin
                    if (beat == 24'd0) begin
                        step_pulse <= 1'b1;
                        if (!last_step) begin
                            step_addr <= step_addr + 6'd1;
                            state     <= PLAY;
                            beat      <= STEP_CYCLES - 24'd1;
                        end else if (bus.loop) begin
                            step_addr <= 6'd0;
                            state     <= PLAY;
                            beat      <= STEP_CYCLES - 24'd1;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        beat <= beat - 24'd1;
                        if (state == PLAY && GAP_CYCLES != 24'd0 && beat == GAP_CYCLES)
                            state <= GAP;
                    end
                end
                DONE: if (!bus.ena) begin
                    state     <= IDLE;
                    step_addr <= 6'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.step_addr  = step_addr;
    assign bus.counter    = counter;
    assign bus.divider    = divider;
    assign bus.step_pulse = step_pulse;
    assign bus.playing    = bus.ena & (state == PLAY || state == GAP);
    assign bus.done       = (state == DONE);
endmodule
